// File: rtl/sc2bin_cnt.sv
// Stochastic-to-binary window counter: popcounts SC lanes over a beat window,
// saturates, and hands the count to the shift/truncate stage via valid/ready.
module sc2bin_cnt #(
    parameter int SC_LANES     = 4,
    parameter int BITWIDTH_OUT = 10,
    parameter int WIN_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [SC_LANES-1:0]     sc_in,
    input  logic                    sc_vld,
    output logic [BITWIDTH_OUT-1:0] cnt_out,
    output logic                    cnt_vld,
    input  logic                    cnt_rdy,
    output logic                    sat,
    output logic                    busy
);

    localparam int PC_W  = $clog2(SC_LANES + 1);
    localparam int SUM_W = BITWIDTH_OUT + 1;
    localparam int REM_W = WIN_W + 1;
    localparam logic [BITWIDTH_OUT-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                  state;
    logic [BITWIDTH_OUT-1:0] acc;
    logic [REM_W-1:0]        rem;
    logic                    sat_r;

    logic [PC_W-1:0]         pc;
    logic [SUM_W-1:0]        sum;
    logic                    ovf;
    logic [BITWIDTH_OUT-1:0] clip;
    logic [REM_W-1:0]        rem_load;
    logic                    last_beat;

    always_comb begin
        pc = '0;
        for (int i = 0; i < SC_LANES; i++) begin
            pc = pc + PC_W'(sc_in[i]);
        end
    end

    // One extra sum bit so overflow is seen before clipping.
    assign sum  = SUM_W'(acc) + SUM_W'(pc);
    assign ovf  = sum > SUM_W'(CNT_MAX);
    assign clip = ovf ? CNT_MAX : sum[BITWIDTH_OUT-1:0];

    // A zero length field means the full 2^WIN_W window.
    assign rem_load  = (win_len == '0) ? {1'b1, {WIN_W{1'b0}}}
                                       : {1'b0, win_len};
    assign last_beat = (rem == REM_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            rem     <= '0;
            sat_r   <= 1'b0;
            cnt_out <= '0;
            cnt_vld <= 1'b0;
            sat     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCUM;
                        acc   <= '0;
                        sat_r <= 1'b0;
                        rem   <= rem_load;
                        busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (sc_vld) begin
                        acc   <= clip;
                        sat_r <= sat_r | ovf;
                        rem   <= rem - REM_W'(1);
                        if (last_beat) begin
                            state   <= S_DONE;
                            cnt_out <= clip;
                            sat     <= sat_r | ovf;
                            cnt_vld <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (cnt_rdy) begin
                        cnt_vld <= 1'b0;
                        if (start) begin
                            state <= S_ACCUM;
                            acc   <= '0;
                            sat_r <= 1'b0;
                            rem   <= rem_load;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt_vld <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc2bin_cnt.sv
// Directed + randomized bench for sc2bin_cnt against a popcount/min model.
module tb_sc2bin_cnt;

    localparam int SC_LANES     = 4;
    localparam int BITWIDTH_OUT = 10;
    localparam int WIN_W        = 8;
    localparam int CMAX         = (1 << BITWIDTH_OUT) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [WIN_W-1:0]        win_len;
    logic [SC_LANES-1:0]     sc_in;
    logic                    sc_vld;
    logic [BITWIDTH_OUT-1:0] cnt_out;
    logic                    cnt_vld;
    logic                    cnt_rdy;
    logic                    sat;
    logic                    busy;

    int vectors = 0;
    int errs    = 0;

    sc2bin_cnt #(
        .SC_LANES(SC_LANES),
        .BITWIDTH_OUT(BITWIDTH_OUT),
        .WIN_W(WIN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .win_len(win_len),
        .sc_in(sc_in),
        .sc_vld(sc_vld),
        .cnt_out(cnt_out),
        .cnt_vld(cnt_vld),
        .cnt_rdy(cnt_rdy),
        .sat(sat),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bits_mode: 0 ones, 1 zeros, 2 random, 3 ramp 0001/0011/0111/1111
    // stall_mode: 0 none, 1 alternate, 2 random
    task automatic run_window(input int len_field, input int bits_mode,
                              input int stall_mode, input bit poke_start);
        int n, beats, expc;
        bit vld, phase;
        logic [SC_LANES-1:0] v;
        n     = (len_field == 0) ? (1 << WIN_W) : len_field;
        beats = 0;
        expc  = 0;
        phase = 1'b0;
        win_len = WIN_W'(len_field);
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("vld_after_start", cnt_vld, 0);
        while (beats < n) begin
            case (stall_mode)
                0: vld = 1'b1;
                1: begin vld = !phase; phase = !phase; end
                default: vld = ($urandom % 3) != 0;
            endcase
            case (bits_mode)
                0: v = '1;
                1: v = '0;
                2: v = SC_LANES'($urandom);
                default: v = SC_LANES'((1 << ((beats % 4) + 1)) - 1);
            endcase
            sc_vld = vld;
            sc_in  = vld ? v : SC_LANES'($urandom);
            start  = poke_start ? (($urandom % 4) == 0) : 1'b0;
            step();
            if (vld) begin
                expc += $countones(v);
                beats++;
            end
            if (beats < n) chk("vld_early", cnt_vld, 0);
        end
        start  = 1'b0;
        sc_vld = 1'b0;
        chk("vld_done", cnt_vld, 1);
        chk("cnt", cnt_out, (expc > CMAX) ? CMAX : expc);
        chk("sat", sat, (expc > CMAX) ? 1 : 0);
        chk("busy_done", busy, 1);
    endtask

    task automatic ack_idle();
        cnt_rdy = 1'b1;
        start   = 1'b0;
        step();
        cnt_rdy = 1'b0;
        chk("vld_after_ack", cnt_vld, 0);
        chk("busy_after_ack", busy, 0);
    endtask

    initial begin
        logic [BITWIDTH_OUT-1:0] held_cnt;
        logic                    held_sat;
        reset   = 1'b1;
        start   = 1'b0;
        win_len = '0;
        sc_in   = '0;
        sc_vld  = 1'b0;
        cnt_rdy = 1'b0;
        #12;
        chk("rst_cnt", cnt_out, 0);
        chk("rst_vld", cnt_vld, 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle beats must not count toward anything.
        sc_vld = 1'b1;
        sc_in  = '1;
        repeat (3) begin
            step();
            chk("idle_vld", cnt_vld, 0);
        end
        sc_vld = 1'b0;

        run_window(8, 0, 0, 1'b0);
        ack_idle();
        run_window(4, 3, 1, 1'b0);
        ack_idle();
        run_window(0, 0, 0, 1'b0);
        ack_idle();
        run_window(5, 1, 0, 1'b0);
        ack_idle();
        run_window(1, 0, 0, 1'b0);
        ack_idle();

        for (int i = 0; i < 8; i++) begin
            run_window(int'($urandom_range(1, 20)), 2, 2, 1'b1);
            ack_idle();
        end

        // Backpressure: result holds, start ignored without a handshake.
        run_window(6, 2, 2, 1'b0);
        held_cnt = cnt_out;
        held_sat = sat;
        for (int i = 0; i < 5; i++) begin
            start  = (i % 2) == 0;
            sc_vld = 1'b1;
            sc_in  = SC_LANES'($urandom);
            step();
            chk("bp_vld", cnt_vld, 1);
            chk("bp_cnt", cnt_out, held_cnt);
            chk("bp_sat", sat, held_sat);
        end
        sc_vld = 1'b0;
        ack_idle();
        step();
        chk("bp_stay_idle", busy, 0);

        // Back-to-back windows of length 2, ones then zeros.
        win_len = 8'd2;
        start   = 1'b1;
        cnt_rdy = 1'b1;
        sc_vld  = 1'b1;
        step();
        for (int w = 0; w < 6; w++) begin
            for (int b = 0; b < 2; b++) begin
                sc_in = (w % 2) ? '0 : '1;
                step();
                if (b == 1) begin
                    chk("b2b_vld", cnt_vld, 1);
                    chk("b2b_cnt", cnt_out, (w % 2) ? 0 : 8);
                end else begin
                    chk("b2b_gap", cnt_vld, 0);
                end
            end
            sc_in = SC_LANES'($urandom);
            if (w == 5) start = 1'b0;
            step();
            chk("b2b_ack", cnt_vld, 0);
            chk("b2b_busy", busy, (w == 5) ? 0 : 1);
        end
        cnt_rdy = 1'b0;
        sc_vld  = 1'b0;

        // Asynchronous reset partway through a window.
        win_len = 8'd8;
        start   = 1'b1;
        step();
        start  = 1'b0;
        sc_vld = 1'b1;
        sc_in  = '1;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_cnt", cnt_out, 0);
        chk("mid_rst_vld", cnt_vld, 0);
        chk("mid_rst_sat", sat, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sc_vld = 1'b1;
            sc_in  = SC_LANES'($urandom);
            step();
            chk("post_rst_vld", cnt_vld, 0);
            chk("post_rst_busy", busy, 0);
        end
        sc_vld = 1'b0;
        run_window(8, 2, 0, 1'b0);
        ack_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
